pipelined_prefix_adder: RTL and testbench

//  Parametrised, pipelined Kogge-Stone prefix adder/subtractor with a valid/ready handshake
//  on both sides. Successor to the fixed 16-bit combinational prefix adder, for datapaths

---
 rtl/prefix_pkg.sv | 26 ++
 rtl/prefix_level.sv | 24 ++
 rtl/pipelined_prefix_adder.sv | 166 ++++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_pkg.sv
// Shared helpers for the pipelined Kogge-Stone prefix adder.
//   MAX_WIDTH  : widest supported operand
//   clog2      : ceiling log2, used to size the prefix tree
//   rank_level : prefix level after which pipeline rank r sits
package prefix_pkg;

  localparam int MAX_WIDTH = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  // Rank 0 is the g/p generation point (position 0); the last rank always
  // closes the tree at level L so the final carry/sum step follows it.
  function automatic int rank_level(input int r, input int stages, input int l);
    if (r <= 0) return 0;
    if (r >= stages) return l;
    return (r * l) / stages;
  endfunction

endpackage

// File: rtl/prefix_level.sv
// One combinational Kogge-Stone prefix level.
//   i_g, i_p : group generate/propagate from the previous level
//   o_g, o_p : groups extended by DIST bit positions; bits below DIST pass through
module prefix_level #(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_g,
  output logic [WIDTH-1:0] o_p
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < DIST) begin : g_pass
      assign o_g[i] = i_g[i];
      assign o_p[i] = i_p[i];
    end else begin : g_comb
      assign o_g[i] = i_g[i] | (i_p[i] & i_g[i-DIST]);
      assign o_p[i] = i_p[i] & i_p[i-DIST];
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready on both sides.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake
//   term0, term1         : operands A and B
//   cin                  : carry in (ignored when sub=1)
//   sub                  : 1 = A-B
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : result, carry out (1 = no borrow on sub), signed overflow
// Latency is STAGES cycles; one result per cycle when out_ready stays high.
module pipelined_prefix_adder
  import prefix_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] term0,
  input  logic [WIDTH-1:0] term1,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int L = clog2(WIDTH);

  if (WIDTH < 4 || WIDTH > MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_prefix_adder: WIDTH must be a power of two in 4..64");
  end
  if (STAGES < 1 || STAGES > L + 1) begin : g_bad_stages
    $error("pipelined_prefix_adder: STAGES must be in 1..log2(WIDTH)+1");
  end

  // ---- valid / advance chain ----
  logic [STAGES:1]   r_vld;
  logic [STAGES+1:1] w_load;
  logic [STAGES:1]   w_prev;

  // A rank loads when it is empty or the rank after it is loading; the
  // output rank's successor is the downstream consumer.
  always_comb begin
    w_load = '0;
    w_load[STAGES+1] = out_ready;
    for (int r = STAGES; r >= 1; r--) begin
      w_load[r] = !r_vld[r] | w_load[r+1];
    end
  end

  always_comb begin
    w_prev = '0;
    w_prev[1] = in_valid;
    for (int r = 2; r <= STAGES; r++) begin
      w_prev[r] = r_vld[r-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      for (int r = 1; r <= STAGES; r++) begin
        if (w_load[r]) r_vld[r] <= w_prev[r];
      end
    end
  end

  assign in_ready  = w_load[1];
  assign out_valid = r_vld[STAGES];

  // ---- P0: generate / propagate ----
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_src_g  [STAGES];
  logic [WIDTH-1:0] w_src_p  [STAGES];
  logic [WIDTH-1:0] w_src_x  [STAGES];
  logic [STAGES-1:0] w_src_c0;

  assign w_bx        = term1 ^ {WIDTH{sub}};
  assign w_src_g[0]  = term0 & w_bx;
  assign w_src_p[0]  = term0 ^ w_bx;
  assign w_src_x[0]  = term0 ^ w_bx;
  assign w_src_c0[0] = sub | cin;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  for (genvar r = 1; r <= STAGES; r++) begin : g_rank
    localparam int LO = rank_level(r - 1, STAGES, L);
    localparam int HI = rank_level(r, STAGES, L);

    logic [WIDTH-1:0] w_g [L+1];
    logic [WIDTH-1:0] w_p [L+1];

    assign w_g[0] = w_src_g[r-1];
    assign w_p[0] = w_src_p[r-1];

    // Only the levels that fall between this rank and the previous one are
    // built here; the rest of the chain is a straight pass-through.
    for (genvar k = 1; k <= L; k++) begin : g_lvl
      if (k > LO && k <= HI) begin : g_on
        prefix_level #(
          .WIDTH(WIDTH),
          .DIST (1 << (k - 1))
        ) u_lvl (
          .i_g(w_g[k-1]),
          .i_p(w_p[k-1]),
          .o_g(w_g[k]),
          .o_p(w_p[k])
        );
      end else begin : g_off
        assign w_g[k] = w_g[k-1];
        assign w_p[k] = w_p[k-1];
      end
    end

    if (r < STAGES) begin : g_mid
      // ---- rank r: partial prefix register ----
      logic [WIDTH-1:0] r_g;
      logic [WIDTH-1:0] r_p;
      logic [WIDTH-1:0] r_x;
      logic             r_c0;

      always_ff @(posedge clk) begin
        if (w_load[r]) begin
          r_g  <= w_g[L];
          r_p  <= w_p[L];
          r_x  <= w_src_x[r-1];
          r_c0 <= w_src_c0[r-1];
        end
      end

      assign w_src_g[r]  = r_g;
      assign w_src_p[r]  = r_p;
      assign w_src_x[r]  = r_x;
      assign w_src_c0[r] = r_c0;
    end else begin : g_final
      // ---- PF: carries, sum, flags; then the output rank ----
      logic [WIDTH:0]   w_c;
      logic [WIDTH-1:0] w_sum;

      // Carry into bit i+1 is the group generate of [i:0] with c0 folded in.
      assign w_c   = {w_g[L] | (w_p[L] & {WIDTH{w_src_c0[r-1]}}), w_src_c0[r-1]};
      assign w_sum = w_src_x[r-1] ^ w_c[WIDTH-1:0];

      always_ff @(posedge clk) begin
        if (w_load[r]) begin
          r_sum  <= w_sum;
          r_cout <= w_c[WIDTH];
          r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
        end
      end
    end
  end

  // Data registers are not reset, so outputs are masked while no result is held.
  assign sum  = out_valid ? r_sum : '0;
  assign cout = out_valid & r_cout;
  assign ovf  = out_valid & r_ovf;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
module tb_pipelined_prefix_adder;

  localparam int W  = 16;
  localparam int S  = 2;
  localparam int W2 = 32;
  localparam int S2 = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0]  term0, term1, sum;
  logic          b_in_valid, b_in_ready, b_cin, b_sub, b_out_valid, b_out_ready, b_cout, b_ovf;
  logic [W2-1:0] b_term0, b_term1, b_sum;

  pipelined_prefix_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .term0(term0), .term1(term1), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_prefix_adder #(.WIDTH(W2), .STAGES(S2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .term0(b_term0), .term1(b_term1), .cin(b_cin), .sub(b_sub),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .sum(b_sum), .cout(b_cout), .ovf(b_ovf)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: true signed / unsigned arithmetic on the operands, returns {ovf, cout, sum}.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic sb, input int w);
    logic [63:0] mask, u;
    longint      lim, sa, sbv, t;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    lim  = longint'(64'd1 << (w - 1));
    sa   = a[w-1] ? longint'(a) - 2 * lim : longint'(a);
    sbv  = b[w-1] ? longint'(b) - 2 * lim : longint'(b);
    if (sb) begin
      t  = sa - sbv;
      co = (a >= b);
    end else begin
      t  = sa + sbv + longint'(ci);
      u  = a + b + 64'(ci);
      co = u[w];
    end
    ov = (t >= lim) || (t < -lim);
    return {ov, co, 64'(t) & mask};
  endfunction

  function automatic logic [63:0] rop(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return mask;
      2:       return 64'd1 << (w - 1);
      3:       return (64'd1 << (w - 1)) - 64'd1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  // Call at a negedge with the pipe empty; returns at the negedge where the result shows.
  task automatic send_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb, input logic [W-1:0] esum,
                          input logic ecout, input logic eovf);
    in_valid = 1'b1; term0 = a; term1 = b; cin = ci; sub = sb; out_ready = 1'b1;
    #1 chk({nm, "_in_ready"}, in_ready, 1);
    repeat (S - 1) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk({nm, "_early_valid"}, out_valid, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({nm, "_out_valid"}, out_valid, 1);
    chk({nm, "_sum"}, sum, esum);
    chk({nm, "_cout"}, cout, ecout);
    chk({nm, "_ovf"}, ovf, eovf);
  endtask

  task automatic stream_a(input int n, input int st_lo, input int st_hi,
                          input bit rnd_rdy, input bit chk_thru);
    logic [65:0]  expq [$];
    logic [65:0]  e;
    logic [W+1:0] hv;
    logic [63:0]  a, b;
    logic         ci, sb, held;
    int           sent, got, cyc;
    held = 1'b0; sent = 0; got = 0; cyc = 0;
    a = rop(W); b = rop(W); ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
    while (got < n && cyc < 4 * n + 50) begin
      @(negedge clk);
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      else         out_ready = !(cyc >= st_lo && cyc <= st_hi);
      in_valid = (sent < n);
      term0 = a[W-1:0]; term1 = b[W-1:0]; cin = ci; sub = sb;
      #1;
      if (cyc >= st_lo && cyc <= st_hi) chk("stall_in_ready", in_ready, 0);
      if (held) begin
        chk("held_valid", out_valid, 1);
        chk("held_stable", {ovf, cout, sum}, hv);
      end
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_out", out_valid, 0);
          end else begin
            e = expq.pop_front();
            chk("a_sum", sum, e[W-1:0]);
            chk("a_cout", cout, e[64]);
            chk("a_ovf", ovf, e[65]);
          end
          got++;
        end else begin
          held = 1'b1;
          hv = {ovf, cout, sum};
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, ci, sb, W));
        sent++;
        a = rop(W); b = rop(W); ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("a_stream_count", got, n);
    if (chk_thru) chk("a_throughput_cycles", cyc, n + S);
  endtask

  task automatic stream_b(input int n, input bit rnd);
    logic [65:0]   expq [$];
    logic [65:0]   e;
    logic [W2+1:0] hv;
    logic [63:0]   a, b;
    logic          ci, sb, held;
    int            sent, got, cyc;
    held = 1'b0; sent = 0; got = 0; cyc = 0;
    a = rop(W2); b = rop(W2); ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
    while (got < n && cyc < 4 * n + 50) begin
      @(negedge clk);
      b_out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      b_in_valid  = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      b_term0 = a[W2-1:0]; b_term1 = b[W2-1:0]; b_cin = ci; b_sub = sb;
      #1;
      if (held) chk("b_held_stable", {b_ovf, b_cout, b_sum}, hv);
      held = 1'b0;
      if (b_out_valid) begin
        if (b_out_ready) begin
          if (expq.size() == 0) begin
            chk("b_unexpected_out", b_out_valid, 0);
          end else begin
            e = expq.pop_front();
            chk("b_sum", b_sum, e[W2-1:0]);
            chk("b_cout", b_cout, e[64]);
            chk("b_ovf", b_ovf, e[65]);
          end
          got++;
        end else begin
          held = 1'b1;
          hv = {b_ovf, b_cout, b_sum};
        end
      end
      if (b_in_valid && b_in_ready) begin
        expq.push_back(model(a, b, ci, sb, W2));
        sent++;
        a = rop(W2); b = rop(W2); ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    chk("b_stream_count", got, n);
    if (!rnd) chk("b_throughput_cycles", cyc, n + S2);
  endtask

  initial begin
    logic [65:0] e;
    in_valid = 1'b0; term0 = '0; term1 = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_term0 = '0; b_term1 = '0; b_cin = 1'b0; b_sub = 1'b0; b_out_ready = 1'b1;

    tbl[0] = '{16'h6978, 16'h61a8, 1'b0, 1'b0, 16'hcb20, 1'b0, 1'b1};
    tbl[1] = '{16'hee48, 16'h5208, 1'b1, 1'b0, 16'h4051, 1'b1, 1'b0};
    tbl[2] = '{16'hfa00, 16'h2710, 1'b1, 1'b0, 16'h2111, 1'b1, 1'b0};
    tbl[3] = '{16'h7530, 16'h7d00, 1'b0, 1'b1, 16'hf830, 1'b0, 1'b0};
    tbl[4] = '{16'h7530, 16'h7d00, 1'b1, 1'b1, 16'hf830, 1'b0, 1'b0};
    tbl[5] = '{16'hffff, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7fff, 1'b1, 1'b1};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[9] = '{16'h7fff, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};

    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      send_one($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb,
               tbl[i].esum, tbl[i].ecout, tbl[i].eovf);
    end
    @(negedge clk);
    #1 chk("drained_valid", out_valid, 0);

    // Back-pressure: 10 back-to-back vectors, out_ready low for cycles 4..8.
    stream_a(10, 4, 8, 1'b0, 1'b0);

    // Reset with two results in flight.
    @(negedge clk);
    in_valid = 1'b1; term0 = 16'h1234; term1 = 16'h1111; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    term0 = 16'h4321;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("no_stale_valid", out_valid, 0);
    end
    @(negedge clk);
    e = model(64'h0000_0000_0000_abcd, 64'h0000_0000_0000_1234, 1'b1, 1'b0, W);
    send_one("post_rst", 16'habcd, 16'h1234, 1'b1, 1'b0, e[W-1:0], e[64], e[65]);

    // Full throughput, then random back-pressure.
    stream_a(200, -1, -1, 1'b0, 1'b1);
    stream_a(2000, -1, -1, 1'b1, 1'b0);

    // Wider, deeper instance.
    stream_b(200, 1'b0);
    stream_b(2000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
